sortnet_checker: RTL and testbench

Parametrised self-checking stimulus/response harness for the bitonic sorting networks. It replaces the fixed descending-vector frequency wrapper: it drives a sorter's `DIN`/`DINEN`, captures `DOT`/`DOTEN`, and checks every batch. Checks cover sortedness, key conservation, payload integrity, exact expected output and fixed latency. It sits at the top level of FPGA evaluation builds and simulation benches, with the sorter instantiated beside it.

---
 rtl/sortnet_checker.sv | 201 ++++++++++++++++++++
 tb/tb_sortnet_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sortnet_checker.sv
// sortnet_checker: stimulus/response harness for bitonic sorting networks.
// Issues NUM_BATCH vectors, captures each sorted result and counts failing check classes.
module sortnet_checker #(
  parameter int P_LOG     = 7,
  parameter int DATW      = 64,
  parameter int KEYW      = 32,
  parameter int NUM_BATCH = 16,
  parameter int LAT_W     = 16
) (
  input  logic                      CLK,
  input  logic                      RST_IN,
  input  logic                      START,
  input  logic [1:0]                MODE,
  input  logic [31:0]               SEED,
  output logic [(DATW<<P_LOG)-1:0]  DIN,
  output logic                      DINEN,
  input  logic [(DATW<<P_LOG)-1:0]  DOT,
  input  logic                      DOTEN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      PASS,
  output logic [15:0]               ERR_CNT,
  output logic [LAT_W-1:0]          LATENCY,
  output logic [1:0]                ULED
);

  localparam int N    = 1 << P_LOG;
  localparam int VW   = DATW << P_LOG;
  localparam int SUMW = KEYW + P_LOG;
  localparam int BW   = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] GOLDEN    = 32'h9E37_79B9;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FIN} state_t;

  state_t             state;
  logic [1:0]         mode_r;
  logic [31:0]        seed_r;
  logic [31:0]        lfsr;
  logic [BW-1:0]      batch;
  logic [LAT_W-1:0]   lat_cnt;
  logic [LAT_W-1:0]   meas_lat;
  logic [SUMW-1:0]    ref_sum;
  logic [VW-1:0]      dot_r;

  logic               accept_start;
  logic [1:0]         gen_mode;
  logic [31:0]        gen_lfsr;
  logic [31:0]        gen_seed;
  logic [31:0]        seed_eff;
  logic [VW-1:0]      gen_vec;
  logic [SUMW-1:0]    gen_sum;
  logic               err_a, err_b, err_c, err_d, err_e;
  logic [2:0]         check_inc;
  logic [15:0]        check_err;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  assign accept_start = START && (state == IDLE || state == FIN);
  assign seed_eff     = (SEED == '0) ? 32'd1 : SEED;
  assign ULED         = {PASS, DONE};

  // One generator serves both the first batch (fresh MODE/SEED) and later batches (latched copies).
  always_comb begin
    logic [KEYW-1:0] key;
    logic [31:0]     hash;
    key      = '0;
    hash     = '0;
    gen_mode = accept_start ? MODE     : mode_r;
    gen_lfsr = accept_start ? seed_eff : lfsr;
    gen_seed = accept_start ? SEED     : seed_r;
    gen_vec  = '0;
    gen_sum  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hash = gen_lfsr ^ (i * GOLDEN);
      case (gen_mode)
        2'd0:    key = KEYW'(N - i);
        2'd1:    key = KEYW'(hash);
        2'd2:    key = KEYW'(gen_seed);
        default: key = KEYW'(i + 1);
      endcase
      gen_vec[i*DATW +: DATW] = {{(DATW-KEYW){1'b1}}, key};
      gen_sum = gen_sum + SUMW'(key);
    end
  end

  always_comb begin
    logic [KEYW-1:0] k;
    logic [SUMW-1:0] sum;
    k     = '0;
    sum   = '0;
    err_a = 1'b0;
    err_c = 1'b0;
    err_d = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      k   = dot_r[i*DATW +: KEYW];
      sum = sum + SUMW'(k);
      if (dot_r[i*DATW+KEYW +: DATW-KEYW] != '1) err_c = 1'b1;
      if ((mode_r == 2'd0 || mode_r == 2'd3) && k != KEYW'(i + 1)) err_d = 1'b1;
      if (mode_r == 2'd2 && k != KEYW'(seed_r)) err_d = 1'b1;
    end
    for (int unsigned i = 1; i < N; i++) begin
      if (dot_r[(i-1)*DATW +: KEYW] > dot_r[i*DATW +: KEYW]) err_a = 1'b1;
    end
    err_b     = (sum != ref_sum);
    err_e     = (batch != '0) && (meas_lat != LATENCY);
    check_inc = 3'(err_a) + 3'(err_b) + 3'(err_c) + 3'(err_d) + 3'(err_e) + 3'(DOTEN);
    check_err = sat_add(ERR_CNT, check_inc);
  end

  always_ff @(posedge CLK or negedge RST_IN) begin
    if (!RST_IN) begin
      state    <= IDLE;
      mode_r   <= '0;
      seed_r   <= '0;
      lfsr     <= '0;
      batch    <= '0;
      lat_cnt  <= '0;
      meas_lat <= '0;
      ref_sum  <= '0;
      dot_r    <= '0;
      DIN      <= '0;
      DINEN    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      ERR_CNT  <= '0;
      LATENCY  <= '0;
    end else begin
      DINEN <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (START) begin
            mode_r  <= MODE;
            seed_r  <= SEED;
            lfsr    <= seed_eff;
            batch   <= '0;
            ERR_CNT <= '0;
            LATENCY <= '0;
            DONE    <= 1'b0;
            PASS    <= 1'b0;
            BUSY    <= 1'b1;
            DIN     <= gen_vec;
            ref_sum <= gen_sum;
            DINEN   <= 1'b1;
            lat_cnt <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          lfsr    <= lfsr_next(lfsr);
          lat_cnt <= lat_cnt + 1'b1;
          if (DOTEN) ERR_CNT <= sat_add(ERR_CNT, 3'd1);
          state   <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          // Timeout wins over a coincident DOTEN.
          if (lat_cnt == '1) begin
            ERR_CNT <= sat_add(ERR_CNT, 3'd1);
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            PASS    <= 1'b0;
            state   <= FIN;
          end else if (DOTEN) begin
            dot_r    <= DOT;
            meas_lat <= lat_cnt;
            if (batch == '0) LATENCY <= lat_cnt;
            state    <= CHECK;
          end
        end
        CHECK: begin
          ERR_CNT <= check_err;
          if (batch == BW'(NUM_BATCH - 1)) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (check_err == '0);
            state <= FIN;
          end else begin
            batch   <= batch + 1'b1;
            DIN     <= gen_vec;
            ref_sum <= gen_sum;
            DINEN   <= 1'b1;
            lat_cnt <= '0;
            state   <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sortnet_checker.sv
// Bench for sortnet_checker: a behavioural sorter/scoreboard predicts every output each cycle.
module tb_sortnet_checker;
  localparam int P_LOG = 3;
  localparam int N     = 8;
  localparam int DATW  = 48;
  localparam int KEYW  = 32;
  localparam int NB    = 4;
  localparam int LAT_W = 8;
  localparam int VW    = DATW * N;

  logic             clk = 1'b0;
  logic             rst_n, start, dinen, doten, busy, done, pass;
  logic [1:0]       mode, uled;
  logic [31:0]      seed;
  logic [VW-1:0]    din, dot;
  logic [15:0]      err_cnt;
  logic [LAT_W-1:0] latency;

  sortnet_checker #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW), .NUM_BATCH(NB), .LAT_W(LAT_W)) dut (
    .CLK(clk), .RST_IN(rst_n), .START(start), .MODE(mode), .SEED(seed),
    .DIN(din), .DINEN(dinen), .DOT(dot), .DOTEN(doten),
    .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt), .LATENCY(latency), .ULED(uled));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // run configuration, written by the stimulus process only
  int cfg_lat[NB];
  int cfg_swap_b = -1, cfg_pay_b = -1, cfg_extra_b = -1;
  bit cfg_silent = 1'b0;
  int start_cyc = -10;
  bit lit_on = 1'b0;
  int lit_err, lit_lat, lit_done, lit_uled;

  // reference state, written by the model/compare process only
  int n_chk = 0, n_fail = 0;
  bit active = 0, exp_busy = 0, exp_done = 0, exp_dinen = 0, done_seen = 0;
  int exp_err = 0, exp_lat = 0, bidx = 0;
  int next_issue = -1, due = -1, extra_cyc = -1;
  int ev_err_cyc = -1, ev_err_n = 0, ev_lat_cyc = -1, ev_lat_val = 0, ev_done_cyc = -1;
  logic [31:0] m_lf, m_seed;
  logic [1:0]  m_mode;
  logic [VW-1:0] exp_vec, out_vec = '0, pin_vec;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  function automatic logic [VW-1:0] make_vec(input logic [1:0] m, input logic [31:0] lf, input logic [31:0] sd);
    logic [VW-1:0] v;
    logic [31:0] k;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case (m)
        2'd0: k = 32'(N - i);
        2'd1: k = lf ^ (32'(i) * 32'h9E3779B9);
        2'd2: k = sd;
        default: k = 32'(i + 1);
      endcase
      v[i*DATW +: DATW] = {16'hFFFF, k};
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] v);
    logic [31:0] k[N];
    logic [31:0] t;
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) k[i] = v[i*DATW +: 32];
    for (int i = 1; i < N; i++)
      for (int j = i; j > 0 && k[j-1] > k[j]; j--) begin
        t = k[j]; k[j] = k[j-1]; k[j-1] = t;
      end
    r = '0;
    for (int i = 0; i < N; i++) r[i*DATW +: DATW] = {16'hFFFF, k[i]};
    return r;
  endfunction

  // failing classes for one batch, straight from the check rules
  function automatic int count_errs(input logic [VW-1:0] inv, input logic [VW-1:0] outv,
                                    input logic [1:0] m, input logic [31:0] sd, input int b, input int l, input int l0);
    bit a = 0, c = 0, d = 0;
    longint si = 0, so = 0;
    logic [31:0] ko, kp;
    logic [15:0] po;
    for (int i = 0; i < N; i++) begin
      ko = outv[i*DATW +: 32];
      po = outv[i*DATW+32 +: 16];
      kp = inv[i*DATW +: 32];
      si += longint'(kp);
      so += longint'(ko);
      if (i > 0 && outv[(i-1)*DATW +: 32] > ko) a = 1;
      if (po != 16'hFFFF) c = 1;
      if ((m == 2'd0 || m == 2'd3) && ko != 32'(i + 1)) d = 1;
      if (m == 2'd2 && ko != sd) d = 1;
    end
    return int'(a) + int'((si & 64'h7_FFFF_FFFF) != (so & 64'h7_FFFF_FFFF)) + int'(c) + int'(d)
           + int'(b > 0 && l != l0);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_dinen = 1'b0;
    if (cyc == 1) begin
      chk("pin_lfsr1", lfsr_step(32'h1), 32'h8020_0003);
      chk("pin_lfsr2", lfsr_step(32'h8020_0003), 32'hC030_0002);
      pin_vec = make_vec(2'd1, 32'h1, 32'h0);
      chk("pin_mode1_lane1", pin_vec[DATW +: 32], 32'h9E37_79B8);
      pin_vec = make_vec(2'd0, 32'h1, 32'h0);
      chk("pin_mode0_lane0", pin_vec[0 +: 32], 8);
      pin_vec = sort_vec(pin_vec);
      chk("pin_sorted_lane7", pin_vec[7*DATW +: 32], 8);
      chk("pin_errs_clean", count_errs(make_vec(2'd0, 32'h1, 32'h0), pin_vec, 2'd0, 32'h0, 1, 5, 5), 0);
    end
    if (!rst_n) begin
      active = 0; exp_busy = 0; exp_done = 0; exp_err = 0; exp_lat = 0;
      next_issue = -1; ev_err_cyc = -1; ev_lat_cyc = -1; ev_done_cyc = -1;
      chk_vec("din_reset", din, '0);
    end else begin
      if (cyc == start_cyc + 1) begin
        active = 1; exp_busy = 1; exp_done = 0; exp_err = 0; exp_lat = 0; done_seen = 0;
        bidx = 0; next_issue = cyc; ev_err_cyc = -1; ev_lat_cyc = -1; ev_done_cyc = -1;
        m_mode = mode; m_seed = seed; m_lf = (seed == 0) ? 32'h1 : seed;
      end
      if (cyc == ev_err_cyc) exp_err = exp_err + ev_err_n;
      if (cyc == ev_lat_cyc) exp_lat = ev_lat_val;
      if (cyc == ev_done_cyc) begin exp_busy = 0; exp_done = 1; active = 0; end
      if (active && cyc == next_issue) begin
        exp_dinen = 1'b1;
        exp_vec = make_vec(m_mode, m_lf, m_seed);
        chk_vec("din", din, exp_vec);
        m_lf = lfsr_step(m_lf);
        if (cfg_silent) begin
          ev_err_cyc = cyc + (1 << LAT_W); ev_err_n = 1; ev_done_cyc = cyc + (1 << LAT_W);
        end else begin
          out_vec = sort_vec(exp_vec);
          if (bidx == cfg_swap_b) out_vec = {out_vec[VW-1:5*DATW], out_vec[3*DATW +: DATW],
                                             out_vec[4*DATW +: DATW], out_vec[3*DATW-1:0]};
          if (bidx == cfg_pay_b) out_vec[7*DATW + 40] = 1'b0;
          due = cyc + cfg_lat[bidx];
          ev_err_n = count_errs(exp_vec, out_vec, m_mode, m_seed, bidx, cfg_lat[bidx], cfg_lat[0]);
          extra_cyc = (bidx == cfg_extra_b) ? due + 1 : -1;
          if (bidx == cfg_extra_b) ev_err_n++;
          ev_err_cyc = due + 2;
          if (bidx == 0) begin ev_lat_cyc = due + 1; ev_lat_val = cfg_lat[0]; end
          if (bidx == NB - 1) ev_done_cyc = due + 2;
          else next_issue = due + 2;
          bidx++;
        end
      end
    end
    doten = (cyc == due) || (cyc == extra_cyc);
    dot   = out_vec;
    chk("dinen", dinen, exp_dinen);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("pass", pass, exp_done && exp_err == 0);
    chk("uled", uled, {exp_done && exp_err == 0, exp_done});
    chk("err_cnt", err_cnt, exp_err);
    chk("latency", latency, exp_lat);
    if (rst_n && exp_done && !done_seen) begin
      done_seen = 1;
      if (lit_on) begin
        chk("lit_done_cycle", cyc, lit_done);
        chk("lit_err_cnt", err_cnt, lit_err);
        chk("lit_latency", latency, lit_lat);
        chk("lit_uled", uled, lit_uled);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_run(input logic [1:0] m, input logic [31:0] sd, input int l0, input int l1, input int l2,
                        input int l3, input int swap_b, input int pay_b, input int extra_b, input bit silent,
                        input int lerr, input int llat, input int ldone_off, input int luled);
    mode = m; seed = sd;
    cfg_lat[0] = l0; cfg_lat[1] = l1; cfg_lat[2] = l2; cfg_lat[3] = l3;
    cfg_swap_b = swap_b; cfg_pay_b = pay_b; cfg_extra_b = extra_b; cfg_silent = silent;
    lit_on = 1; lit_err = lerr; lit_lat = llat; lit_uled = luled;
    next_cyc();
    start_cyc = cyc; lit_done = cyc + ldone_off; start = 1'b1;
    next_cyc();
    start = 1'b0;
    next_cyc();
    for (int k = 0; k < 600 && !exp_done; k++) next_cyc();
    if (!exp_done) begin
      $display("FAIL run_bound: got no completion expected completion within 600 cycles");
      $fatal(1);
    end
    repeat (3) next_cyc();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = '0; seed = '0;
    for (int i = 0; i < NB; i++) cfg_lat[i] = 5;
    repeat (3) next_cyc();
    rst_n = 1'b1;
    while (cyc < 9) next_cyc();
    // ideal sorter, descending stimulus: START at 10, last DINEN at 32, DONE at 39
    do_run(2'd0, 32'h0, 5, 5, 5, 5, -1, -1, -1, 0, 0, 5, 29, 3);
    do_run(2'd1, 32'h0, 5, 5, 5, 5, 1, -1, -1, 0, 1, 5, 29, 1);
    do_run(2'd0, 32'h0, 5, 5, 6, 5, -1, -1, -1, 0, 1, 5, 30, 1);
    do_run(2'd3, 32'h0, 5, 5, 5, 5, -1, -1, -1, 1, 1, 0, 257, 1);
    do_run(2'd2, 32'h1234, 5, 5, 5, 5, -1, 0, -1, 0, 1, 5, 29, 1);
    do_run(2'd2, 32'h1234, 5, 5, 5, 5, -1, 0, 0, 0, 2, 5, 29, 1);
    do_run(2'd1, 32'hDEAD_BEEF ^ $urandom, 5, 5, 5, 5, -1, -1, -1, 0, 0, 5, 29, 3);
    // reset in WAIT; the sorter's late DOTEN then lands while the checker is idle
    mode = 2'd0; seed = 32'h0; lit_on = 0;
    for (int i = 0; i < NB; i++) cfg_lat[i] = 20;
    cfg_swap_b = -1; cfg_pay_b = -1; cfg_extra_b = -1; cfg_silent = 0;
    next_cyc();
    start_cyc = cyc; start = 1'b1;
    next_cyc();
    start = 1'b0;
    while (cyc < start_cyc + 8) next_cyc();
    rst_n = 1'b0;
    repeat (3) next_cyc();
    rst_n = 1'b1;
    while (cyc < start_cyc + 30) next_cyc();
    do_run(2'd3, 32'h0, 3, 3, 3, 3, -1, -1, -1, 0, 0, 3, 21, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
